// File: rtl/scan_tri_gen_if.sv
// Bundle between the relock controller (master) and the triangular scan generator (slave).
// Window limits, operating point and scan value are signed; step and div are unsigned.
interface scan_tri_gen_if #(
  parameter int R  = 14,
  parameter int DW = 16
);
  logic                run_scan;
  logic                track_A;
  logic signed [R-1:0] scan_A;
  logic signed [R-1:0] low_lim;
  logic signed [R-1:0] hig_lim;
  logic        [R-2:0] step;
  logic       [DW-1:0] div;
  logic signed [R-1:0] scan_out;
  logic                scan_trigger;
  logic                dir_up;

  modport master (
    output run_scan, track_A, scan_A, low_lim, hig_lim, step, div,
    input  scan_out, scan_trigger, dir_up
  );

  modport slave (
    input  run_scan, track_A, scan_A, low_lim, hig_lim, step, div,
    output scan_out, scan_trigger, dir_up
  );
endinterface

// File: rtl/scan_tri_gen.sv
// Triangular scan generator: ramps scan_out between low_lim and hig_lim at a divided step rate,
// pulsing scan_trigger once per period at the bottom turn.
module scan_tri_gen #(
  parameter int R  = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  scan_tri_gen_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  state_t              r_state;
  logic signed [R-1:0] r_scan_out;
  logic                r_trigger;
  logic                r_dir_up;
  logic       [DW-1:0] r_div_cnt;

  logic signed [R:0]   w_out_ext;
  logic signed [R:0]   w_step_ext;
  logic signed [R:0]   w_lo_ext;
  logic signed [R:0]   w_hi_ext;
  logic signed [R:0]   w_sum;
  logic signed [R:0]   w_diff;
  logic                w_tick;
  logic                w_degen;
  logic                w_step_nz;

  // One extra bit of headroom so a full-scale step can never wrap before the limit compare.
  assign w_out_ext  = {r_scan_out[R-1], r_scan_out};
  assign w_step_ext = {2'b00, bus.step};
  assign w_lo_ext   = {bus.low_lim[R-1], bus.low_lim};
  assign w_hi_ext   = {bus.hig_lim[R-1], bus.hig_lim};
  assign w_sum      = w_out_ext + w_step_ext;
  assign w_diff     = w_out_ext - w_step_ext;
  assign w_tick     = (r_div_cnt == bus.div);
  assign w_degen    = (bus.low_lim >= bus.hig_lim);
  assign w_step_nz  = (bus.step != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_scan_out <= '0;
      r_trigger  <= 1'b0;
      r_dir_up   <= 1'b1;
      r_div_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_trigger <= 1'b0;
          r_div_cnt <= '0;
          if (bus.run_scan) begin
            r_state  <= S_UP;
            r_dir_up <= 1'b1;
          end else if (bus.track_A) begin
            r_scan_out <= bus.scan_A;
          end
        end
        S_UP, S_DOWN: begin
          r_trigger <= 1'b0;
          if (!bus.run_scan) begin
            // Value is held on the exit cycle; a trigger due this cycle is dropped.
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
            if (w_degen) begin
              r_scan_out <= bus.low_lim;
              r_state    <= S_UP;
              r_dir_up   <= 1'b1;
              r_trigger  <= w_tick;
            end else if (r_scan_out > bus.hig_lim) begin
              r_scan_out <= bus.hig_lim;
              r_state    <= S_DOWN;
              r_dir_up   <= 1'b0;
            end else if (r_scan_out < bus.low_lim) begin
              r_scan_out <= bus.low_lim;
              r_state    <= S_UP;
              r_dir_up   <= 1'b1;
              r_trigger  <= 1'b1;
            end else if (w_tick && w_step_nz) begin
              // Zero step never reaches the turn logic, so a stalled ramp cannot fire triggers.
              if (r_state == S_UP) begin
                if (w_sum >= w_hi_ext) begin
                  r_scan_out <= bus.hig_lim;
                  r_state    <= S_DOWN;
                  r_dir_up   <= 1'b0;
                end else begin
                  r_scan_out <= w_sum[R-1:0];
                end
              end else begin
                if (w_diff <= w_lo_ext) begin
                  r_scan_out <= bus.low_lim;
                  r_state    <= S_UP;
                  r_dir_up   <= 1'b1;
                  r_trigger  <= 1'b1;
                end else begin
                  r_scan_out <= w_diff[R-1:0];
                end
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.scan_out     = r_scan_out;
  assign bus.scan_trigger = r_trigger;
  assign bus.dir_up       = r_dir_up;
endmodule

// File: tb/tb_scan_tri_gen.sv
// Scoreboard bench: an integer model predicts scan_out/scan_trigger/dir_up per clock,
// a separate monitor compares the DUT against the queued predictions.
module tb_scan_tri_gen;
  localparam int R  = 14;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_tri_gen_if #(.R(R), .DW(DW)) bus ();
  scan_tri_gen #(.R(R), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int scan;
    bit trig;
    bit up;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus values
  bit s_rst, s_run, s_track;
  int s_A, s_lo, s_hi, s_step, s_div;

  // model state: scanning flag, direction, value, trigger, clocks since last tick
  bit m_scanning, m_up, m_trig;
  int m_scan, m_cnt;

  task automatic model_step();
    bit tick;
    int t;
    if (!s_rst) begin
      m_scanning = 0; m_scan = 0; m_trig = 0; m_up = 1; m_cnt = 0;
    end else if (!m_scanning) begin
      m_trig = 0; m_cnt = 0;
      if (s_run) begin
        m_scanning = 1; m_up = 1;
      end else if (s_track) begin
        m_scan = s_A;
      end
    end else if (!s_run) begin
      m_scanning = 0; m_trig = 0; m_cnt = 0;
    end else begin
      tick = (m_cnt == s_div);
      m_cnt = tick ? 0 : (m_cnt + 1) % (1 << DW);
      m_trig = 0;
      if (s_lo >= s_hi) begin
        m_scan = s_lo; m_up = 1; m_trig = tick;
      end else if (m_scan > s_hi) begin
        m_scan = s_hi; m_up = 0;
      end else if (m_scan < s_lo) begin
        m_scan = s_lo; m_up = 1; m_trig = 1;
      end else if (tick && s_step != 0) begin
        t = m_up ? m_scan + s_step : m_scan - s_step;
        if (m_up && t >= s_hi) begin
          m_scan = s_hi; m_up = 0;
        end else if (!m_up && t <= s_lo) begin
          m_scan = s_lo; m_up = 1; m_trig = 1;
        end else begin
          m_scan = t;
        end
      end
    end
  endtask

  // Drive inputs at the falling edge, predict the post-edge outputs, queue them.
  task automatic apply_cycle();
    exp_t e;
    rst          = s_rst;
    bus.run_scan = s_run;
    bus.track_A  = s_track;
    bus.scan_A   = s_A[R-1:0];
    bus.low_lim  = s_lo[R-1:0];
    bus.hig_lim  = s_hi[R-1:0];
    bus.step     = s_step[R-2:0];
    bus.div      = s_div[DW-1:0];
    model_step();
    e.scan = m_scan; e.trig = m_trig; e.up = m_up;
    exp_q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_cycle();
  endtask

  task automatic run_until(input int target, input bit want_up, input int max_cyc);
    int n = 0;
    while (!(m_scanning && m_scan == target && m_up == want_up) && n < max_cyc) begin
      apply_cycle();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL reach_target got=%0d required=%0d within %0d cycles", m_scan, target, max_cyc);
    end
  endtask

  task automatic seg_done(input string name);
    $display("seg %-10s cycle=%0d checks=%0d errors=%0d", name, cyc, checks, errors);
  endtask

  task automatic go_idle(input int n);
    s_run = 0;
    run_cycles(n);
  endtask

  // Monitor: every cycle is an output presentation; compare against the oldest prediction.
  initial begin
    exp_t e;
    int act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = bus.scan_out;
        checks += 3;
        if (act != e.scan) begin
          errors++;
          if (errors < 40) $display("FAIL scan_out t=%0t got=%0d required=%0d", $time, act, e.scan);
        end
        if (bus.scan_trigger !== e.trig) begin
          errors++;
          if (errors < 40) $display("FAIL scan_trigger t=%0t got=%b required=%b", $time, bus.scan_trigger, e.trig);
        end
        if (bus.dir_up !== e.up) begin
          errors++;
          if (errors < 40) $display("FAIL dir_up t=%0t got=%b required=%b", $time, bus.dir_up, e.up);
        end
      end
    end
  end

  initial begin
    s_rst = 0; s_run = 1; s_track = 0; s_A = 0;
    s_lo = -100; s_hi = 100; s_step = 50; s_div = 0;
    m_scanning = 0; m_up = 1; m_trig = 0; m_scan = 0; m_cnt = 0;
    @(negedge clk);

    // reset held with run_scan high, then release into the basic triangle
    run_cycles(3);
    seg_done("reset");
    s_rst = 1;
    run_cycles(20);
    seg_done("triangle");

    // divided step rate
    go_idle(2);
    s_track = 1; s_A = 0; run_cycles(1); s_track = 0;
    s_div = 3; s_step = 10; s_lo = -20; s_hi = 20; s_run = 1;
    run_cycles(40);
    seg_done("divider");

    // window widening and shrinking while ramping down through -8
    go_idle(1);
    s_track = 1; s_A = 0; run_cycles(1); s_track = 0;
    s_div = 0; s_step = 8; s_lo = -16; s_hi = 16; s_run = 1;
    run_until(-8, 0, 20);
    s_lo = -32; s_hi = 32;
    run_cycles(5);
    run_until(-8, 0, 40);
    s_lo = -4; s_hi = 4;
    run_cycles(6);
    seg_done("window");

    // full-scale step near the top of range
    go_idle(1);
    s_track = 1; s_A = 8000; run_cycles(1); s_track = 0;
    s_lo = -8192; s_hi = 8191; s_step = 8191; s_div = 0; s_run = 1;
    run_cycles(10);
    seg_done("saturate");

    // exit holds the value, then tracking takes over
    go_idle(1);
    s_track = 1; s_A = 37; run_cycles(1); s_track = 0;
    s_lo = -100; s_hi = 100; s_step = 0; s_run = 1;
    run_cycles(4);
    s_run = 0; run_cycles(4);
    s_track = 1; s_A = -5; run_cycles(3);
    s_track = 0;
    seg_done("exit_track");

    // degenerate window: pinned at low_lim, trigger every tick
    s_lo = 10; s_hi = 5; s_step = 3; s_div = 1; s_run = 1;
    run_cycles(10);
    seg_done("degenerate");

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        s_run = ~s_run;
        if (!m_scanning || !s_run) s_div = (s_run && m_scanning) ? s_div : $urandom_range(0, 3);
      end
      if ($urandom_range(0, 49) == 0) begin
        s_lo = int'($urandom_range(0, 16383)) - 8192;
        s_hi = int'($urandom_range(0, 16383)) - 8192;
        if ($urandom_range(0, 7) != 0 && s_lo > s_hi) begin
          int tmp = s_lo; s_lo = s_hi; s_hi = tmp;
        end
      end
      if ($urandom_range(0, 29) == 0) s_step = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 8191));
      s_track = $urandom_range(0, 1);
      s_A = int'($urandom_range(0, 16383)) - 8192;
      s_rst = ($urandom_range(0, 999) != 0);
      if (!s_run || !m_scanning) begin
        // div may only change while the divider is parked at zero
        if ($urandom_range(0, 9) == 0) s_div = $urandom_range(0, 3);
      end
      apply_cycle();
      if (i % 1000 == 999) seg_done("random");
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
